// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch fault causes and fetch state encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_OOB      = 2'd1,
    FAULT_MISALIGN = 2'd2
  } fault_cause_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN        = 2'd0;
  localparam state_t ST_FAULT_PEND = 2'd1;
  localparam state_t ST_HALT       = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with synchronous flush and push-while-full
// when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);

  // Storage is cleared only by reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC register, bounds/alignment checking against code
// memory, fault state machine and the prefetch FIFO feeding decode.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int          MEM_SIZE = 1024,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  state_t        state;
  fault_cause_t  cause_q;
  logic [31:0]   fault_pc_q;
  logic [CW-1:0] count;
  logic          empty;
  logic [63:0]   head;
  logic          deq;
  logic          has_space;
  logic          in_range;
  logic          aligned;
  logic          bad_pc;
  logic          do_fetch;

  // 33-bit sum so a PC that wrapped past the top of the address space is out of range.
  assign in_range  = ({1'b0, fetch_pc} + 33'd3) < 33'(MEM_SIZE);
  assign aligned   = (fetch_pc[1:0] == 2'b00);
  assign bad_pc    = !in_range || !aligned;
  assign deq       = out_valid && out_ready;
  assign has_space = (count < CW'(DEPTH)) || deq;
  assign do_fetch  = (state == ST_RUN) && !redirect_valid && !bad_pc && has_space;

  assign mem_addr    = fetch_pc;
  assign out_valid   = !empty && (state != ST_HALT);
  assign out_pc      = head[63:32];
  assign out_inst    = head[31:0];
  assign fault       = (state == ST_HALT);
  assign fault_cause = cause_q;
  assign fault_pc    = fault_pc_q;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (do_fetch),
    .push_data ({fetch_pc, mem_inst}),
    .pop       (deq),
    .head_data (head),
    .empty     (empty),
    .count     (count)
  );

  // A redirect wins in every state; otherwise a bad PC parks the unit until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      state      <= ST_RUN;
      cause_q    <= FAULT_NONE;
      fault_pc_q <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      state      <= ST_RUN;
      cause_q    <= FAULT_NONE;
      fault_pc_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bad_pc) begin
            fault_pc_q <= fetch_pc;
            cause_q    <= !in_range ? FAULT_OOB : FAULT_MISALIGN;
            state      <= empty ? ST_HALT : ST_FAULT_PEND;
          end else if (do_fetch) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        ST_FAULT_PEND: begin
          if (empty) state <= ST_HALT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a 1 KiB instance for streaming, backpressure,
// redirect, misalignment and async reset, plus a 16-byte instance for bounds faults.
module tb_inst_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [31:0] mem_addr, mem_inst, redirect_pc, out_inst, out_pc, fault_pc;
  logic        redirect_valid, out_valid, out_ready, fault;
  logic [1:0]  fault_cause;

  logic [31:0] m16_addr, m16_inst, r16_pc, inst16, pc16, fpc16;
  logic        r16_valid, v16, rdy16, fault16;
  logic [1:0]  cause16;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp16_q[$];
  logic [63:0] e_main;
  logic [63:0] e_16;

  always #5 clk = ~clk;

  // Each word encodes its own address so a lost or repeated beat is visible.
  function automatic logic [31:0] code(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  assign mem_inst = code(mem_addr);
  assign m16_inst = (({1'b0, m16_addr} + 33'd3) < 33'd16) ? code(m16_addr) : 32'hDEADDEAD;

  inst_fetch #(.MEM_SIZE(1024), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_inst(mem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc)
  );

  inst_fetch #(.MEM_SIZE(16), .RESET_PC(32'h0), .DEPTH(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .mem_addr(m16_addr), .mem_inst(m16_inst),
    .redirect_valid(r16_valid), .redirect_pc(r16_pc),
    .out_valid(v16), .out_ready(rdy16), .out_inst(inst16), .out_pc(pc16),
    .fault(fault16), .fault_cause(cause16), .fault_pc(fpc16)
  );

  // Every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL beat: got pc %h inst %h, required no beat", out_pc, out_inst);
      end else begin
        e_main = exp_q.pop_front();
        if ({out_pc, out_inst} !== e_main) begin
          errors++;
          $display("[TB] FAIL beat: got pc %h inst %h, required pc %h inst %h",
                   out_pc, out_inst, e_main[63:32], e_main[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v16 && rdy16) begin
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL beat16: got pc %h inst %h, required no beat", pc16, inst16);
      end else begin
        e_16 = exp16_q.pop_front();
        if ({pc16, inst16} !== e_16) begin
          errors++;
          $display("[TB] FAIL beat16: got pc %h inst %h, required pc %h inst %h",
                   pc16, inst16, e_16[63:32], e_16[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, code(pc)});
  endtask

  task automatic push_exp16(input logic [31:0] pc);
    exp16_q.push_back({pc, code(pc)});
  endtask

  // Hold out_ready for exactly n accepting edges.
  task automatic run_beats(input int n);
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, fault, fault_cause} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid %b fault %b cause %0d, required 0 0 0",
               out_valid, fault, fault_cause);
    end
    checks++;
    if ({out_pc, out_inst, fault_pc, mem_addr} !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got pc %h inst %h fpc %h addr %h, required all 0",
               out_pc, out_inst, fault_pc, mem_addr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL first_valid: got valid %b pc %h, required 1 0", out_valid, out_pc);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 4; i++) push_exp(32'(4 * i));
    run_beats(4);
    check_drained("stream_drain");
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_fault: got %b, required 0", fault);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd16 || out_inst !== code(32'd16)) begin
        errors++;
        $display("[TB] FAIL bp_hold: got valid %b pc %h inst %h, required 1 10 %h",
                 out_valid, out_pc, out_inst, code(32'd16));
      end
    end
    checks++;
    if (mem_addr !== 32'd24) begin
      errors++;
      $display("[TB] FAIL bp_stall: got addr %h, required 18", mem_addr);
    end
    for (int i = 0; i < 4; i++) push_exp(32'(16 + 4 * i));
    run_beats(4);
    check_drained("bp_release");
  endtask

  task automatic test_redirect;
    tick();
    push_exp(32'd32);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || mem_addr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL redir_edge1: got valid %b addr %h, required 0 40", out_valid, mem_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      errors++;
      $display("[TB] FAIL redir_edge2: got valid %b pc %h, required 1 40", out_valid, out_pc);
    end
    push_exp(32'h40);
    push_exp(32'h44);
    run_beats(2);
    check_drained("redir_drain");
  endtask

  task automatic test_misalign;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0 || mem_addr !== 32'h42) begin
      errors++;
      $display("[TB] FAIL mis_load: got fault %b valid %b addr %h, required 0 0 42",
               fault, out_valid, mem_addr);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_cause !== FAULT_MISALIGN || fault_pc !== 32'h42 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mis_fault: got fault %b cause %0d fpc %h valid %b, required 1 2 42 0",
               fault, fault_cause, fault_pc, out_valid);
    end
    repeat (3) tick();
    checks++;
    if (fault !== 1'b1 || mem_addr !== 32'h42) begin
      errors++;
      $display("[TB] FAIL mis_hold: got fault %b addr %h, required 1 42", fault, mem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_cause !== FAULT_NONE || fault_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mis_clear: got fault %b cause %0d fpc %h, required 0 0 0",
               fault, fault_cause, fault_pc);
    end
    tick();
    push_exp(32'h100);
    run_beats(1);
    check_drained("mis_resume");
  endtask

  task automatic test_oob;
    for (int i = 0; i < 4; i++) push_exp16(32'(4 * i));
    rdy16 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rdy16 = 1'b0;
    checks++;
    if (exp16_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL oob_drain: got %0d beats outstanding, required 0", exp16_q.size());
      exp16_q.delete();
    end
    checks++;
    if (fault16 !== 1'b0 || v16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oob_pend: got fault %b valid %b, required 0 0", fault16, v16);
    end
    tick();
    checks++;
    if (fault16 !== 1'b1 || cause16 !== FAULT_OOB || fpc16 !== 32'd16 || v16 !== 1'b0 || m16_addr !== 32'd16) begin
      errors++;
      $display("[TB] FAIL oob_fault: got fault %b cause %0d fpc %h valid %b addr %h, required 1 1 10 0 10",
               fault16, cause16, fpc16, v16, m16_addr);
    end
    r16_valid = 1'b1;
    r16_pc    = 32'h0;
    tick();
    r16_valid = 1'b0;
    checks++;
    if (fault16 !== 1'b0 || cause16 !== FAULT_NONE) begin
      errors++;
      $display("[TB] FAIL oob_clear: got fault %b cause %0d, required 0 0", fault16, cause16);
    end
    tick();
    push_exp16(32'h0);
    rdy16 = 1'b1;
    tick();
    rdy16 = 1'b0;
    checks++;
    if (exp16_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL oob_resume: got %0d beats outstanding, required 0", exp16_q.size());
      exp16_q.delete();
    end
  endtask

  task automatic test_async_reset;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ar_pre: got valid %b, required 1", out_valid);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || mem_addr !== 32'h0 || fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_clear: got valid %b pc %h inst %h addr %h fault %b, required 0 0 0 0 0",
               out_valid, out_pc, out_inst, mem_addr, fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push_exp(32'(4 * i));
    run_beats(3);
    check_drained("ar_restart");
  endtask

  initial begin
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rdy16          = 1'b0;
    r16_valid      = 1'b0;
    r16_pc         = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_oob();
    test_async_reset();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the 32-bit CPU. It is the initiator side of the code memory's combinational read port. It holds the program counter and presents word addresses to code memory. It captures each returned instruction with its PC in a small prefetch FIFO and hands them to decode over a valid/ready handshake. The code memory returns undefined data for out-of-range addresses, so this block performs its own bounds and alignment checks and raises a fault instead of issuing a bad access.

## Interface
- MEM_SIZE, 1024: code memory size in bytes. Must match the code memory instance.
- RESET_PC, 32'h0: first fetch address after reset. Must be word-aligned.
- DEPTH, 2: prefetch FIFO entries. Must be 2 or more.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_addr  out  32  byte address to code memory. Always equals fetch_pc.
- mem_inst  in  32  instruction from code memory, combinational from mem_addr.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- fault  out  1  fetch halted on an error. Held until redirect or reset.
- fault_cause  out  2  FAULT_NONE / FAULT_OOB / FAULT_MISALIGN.
- fault_pc  out  32  address that caused the fault.

## Operation
- States: RUN, FAULT_PEND, HALT.
- Reset values: fetch_pc=RESET_PC, FIFO empty, out_valid=0, out_inst=0, out_pc=0, fault=0, fault_cause=FAULT_NONE, fault_pc=0, state RUN.
- Fetch qualifier: fetch happens in RUN when no redirect is present and the FIFO has space. The FIFO has space when count<DEPTH or a dequeue (out_valid&&out_ready) occurs in the same cycle.
- Effect of a fetch: {fetch_pc, mem_inst} is enqueued and fetch_pc += 4.
- Bounds check is done in 33 bits: the address is out of range if {1'b0,fetch_pc}+3 >= MEM_SIZE. Increment wrap past 32'hFFFFFFFC is therefore caught as out of range.
- Error in RUN: if fetch_pc is out of range or fetch_pc[1:0]!=0, no fetch occurs. The block latches fault_pc and fault_cause and moves to FAULT_PEND.
- FAULT_PEND: fetching stops and buffered entries continue to drain. When the FIFO is empty, the block moves to HALT with fault=1.
- HALT: out_valid=0, fetch_pc is frozen.
- Redirect, valid in any state: the FIFO is flushed and fetch_pc <= redirect_pc. fault, fault_cause and fault_pc clear, and the state goes to RUN. The new target is checked on the next cycle like any fetch_pc, so a misaligned target produces FAULT_MISALIGN with fault_pc=redirect_pc.
- Simultaneous redirect and handshake: an accept of the head in the redirect cycle counts as delivered. All other entries are discarded.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clock.

## Timing
- The fetch path is zero-latency combinational through code memory and the capture is registered. The first out_valid is at the first rising edge after rst_n deasserts.
- Throughput is one instruction per cycle with out_ready held high.
- Redirect to first valid output is 2 edges. Edge 1 loads fetch_pc. Edge 2 enqueues the target instruction.
- Backpressure: with out_ready low, the FIFO fills to DEPTH and then fetch_pc stalls. No instruction is lost or duplicated.
- From fault detection, fault rises on the edge after the last buffered entry is accepted. If the FIFO is already empty, it rises on the detection edge.
- out_* are stable while out_valid=1 and out_ready=0.

## Structure
- Shared package cpu_pkg holds the fault_cause enum (FAULT_NONE=0, FAULT_OOB=1, FAULT_MISALIGN=2) and the state enum.
- Sub-module: fetch_fifo, a parameterized DEPTH FIFO of {pc, inst}. It has synchronous flush, simultaneous push/pop when full, and count output.
- The top level contains the PC register, bounds/alignment check and state machine.

## Test plan
- Reset with RESET_PC=0, out_ready=1, code words W0..W3 → out_pc 0,4,8,12 on consecutive cycles with out_inst=W0..W3; fault=0.
- out_ready low for 5 cycles after the first beat → FIFO holds pc 4 and 8, mem_addr stalls at 12. On release, the outputs are 4, 8, 12 with no gap or repeat.
- redirect_valid with redirect_pc=0x40 while the head is pc 8 → FIFO flushed, next out_valid 2 edges later with out_pc=0x40.
- MEM_SIZE=16, out_ready=1 → pcs 0,4,8,12 delivered, then fault=1, fault_cause=FAULT_OOB, fault_pc=16, out_valid=0. A later redirect to 0 clears the fault and resumes at pc 0.
- Redirect to 0x42 → no enqueue, fault_cause=FAULT_MISALIGN, fault_pc=0x42.
- rst_n pulsed low asynchronously mid-stream with FIFO full → outputs reset without a clock edge, and streaming restarts at RESET_PC.
